mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//   Shares the single-port data memory block between the instruction-fetch (IF) and data-memory (DM) stages.
//   Converts each held IF/DM request into the one-cycle memRead/memWrite strobe the memory block needs,
//   and captures its read_data. Returns a one-cycle ack carrying the read data.
//   Sits between the pipeline stage controllers and the memory block.
// PARAMETERS
//   ADDR_W  18  byte-address width, matches memory block address port
//   DATA_W  32  data word width
// PORTS
//   clk                 in   1       system clock, rising edge
//   rst_n               in   1       asynchronous active-low reset
//   if_req              in   1       fetch request, held until if_ack
//   if_addr             in   ADDR_W  fetch byte address (word access)
//   if_ack              out  1       one-cycle fetch completion
//   if_err              out  1       with if_ack: misaligned fetch, no memory access made
//   if_rdata            out  DATA_W  fetch data, valid while if_ack=1
//   dm_req              in   1       data request, held until dm_ack
//   dm_we               in   1       1=store, 0=load
//   dm_byte             in   1       1=byte op (lb/sb), 0=word op
//   dm_addr             in   ADDR_W  data byte address
//   dm_wdata            in   DATA_W  store data (byte op uses [7:0])
//   dm_ack              out  1       one-cycle data completion
//   dm_err              out  1       with dm_ack: misaligned word op, no memory access made
//   dm_rdata            out  DATA_W  load data, valid while dm_ack=1; 0 for stores
//   mem_address         out  ADDR_W  to memory block address
//   mem_write_data      out  DATA_W  to memory block write_data
//   mem_byteOperations  out  1       to memory block byteOperations
//   mem_memRead         out  1       read strobe, exactly one cycle high per load/fetch
//   mem_memWrite        out  1       write strobe, exactly one cycle high per store
//   mem_read_data       in   DATA_W  from memory block read_data
//   busy                out  1       1 in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE, last_grant=IF; all outputs 0, regardless of clk.
//   All outputs are registered. FSM: IDLE -> STROBE -> HOLD -> RESP -> IDLE.
//   IDLE: if any req, arbitrate and latch the winner's addr/we/byte/wdata into the mem_* outputs,
//     with mem_write_data = byte ? {24'b0,wdata[7:0]} : wdata. Go to STROBE. No req: stay in IDLE.
//   Misaligned: word op (IF always, or DM with dm_byte=0) with addr[1:0]!=0 sets an internal err flag.
//   STROBE: mem_memWrite=we (else mem_memRead=1) for this cycle only; both strobes suppressed when err=1.
//   HOLD: both strobes 0; latch mem_read_data (read) or 0 (write/err) into the response register.
//   RESP: winner's ack=1 and err=flag for one cycle; its rdata=response register; other port's ack=0.
//   Latency: request sampled at edge 0 -> strobe in cycle 1 -> ack in cycle 3. Four cycles per access.
//   Back-to-back: a req still high in the IDLE cycle after an ack is a new request.
//     Requesters drop req in their ack cycle if they have no further access.
//   rdata/err outputs return to 0 when ack=0. mem_address/mem_write_data/mem_byteOperations hold the
//     last value until the next grant.
//   Simultaneous IF and DM requests in IDLE are resolved per CONFIGURATION. The loser keeps req high
//     and is served next time it wins arbitration; req is never dropped by the arbiter.
//   req change mid-access: the latched copy is used; a deasserted req still receives its ack.
//   Reset mid-access: return to IDLE immediately, no ack issued. A strobe already raised has taken
//     effect in memory; a strobe not yet raised never occurs.
//   Address wrap: none; addresses pass through unmodified.
// CONFIGURATION
//   MEM_ARB_RR_EN defined: round-robin arbitration. On contention, grant the port not in last_grant;
//     last_grant updates on every grant.
//   MEM_ARB_RR_EN undefined: fixed priority, DM always wins contention (IF can starve); last_grant unused.
// TESTING
//   1. rst_n=0 mid-run -> every output 0 in that cycle; busy=0; after release, idle with no strobes.
//   2. Fetch: mem_read_data=32'h12345678, if_req with if_addr=18'h00010 -> mem_memRead=1 cycle 1 only,
//      mem_address=18'h00010; if_ack=1 in cycle 3 with if_rdata=32'h12345678 and if_err=0.
//   3. Byte store: dm_we=1, dm_byte=1, dm_addr=18'h00007, dm_wdata=32'hDEADBEAB ->
//      mem_memWrite pulse cycle 1, mem_byteOperations=1, mem_write_data=32'h000000AB;
//      dm_ack in cycle 3 with dm_rdata=0.
//   4. Misaligned word load dm_addr=18'h00006 -> no strobe in any cycle; dm_ack=1 and dm_err=1 in cycle 3.
//   5. if_req and dm_req held high for 4 accesses -> RR: grants DM,IF,DM,IF; fixed: DM x4, no if_ack.
//   6. rst_n pulsed low during HOLD of a load -> no dm_ack; the same request after release completes in 4 cycles.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Shares the single-port data memory between the IF and DM stages: one access per four cycles.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise DM has fixed priority over IF.
module mem_access_arbiter #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic              if_err,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic              dm_byte,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic              dm_err,
   output logic [DATA_W-1:0] dm_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_byteOperations,
   output logic              mem_memRead,
   output logic              mem_memWrite,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, STROBE, HOLD, RESP} state_t;

   state_t            state_q, state_d;
   logic              any_req;
   logic              grant_dm;
   logic              grant_dm_q, grant_dm_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
   logic              mem_byte_q, mem_byte_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              if_ack_q, if_ack_d;
   logic              if_err_q, if_err_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              dm_ack_q, dm_ack_d;
   logic              dm_err_q, dm_err_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic [DATA_W-1:0] resp_data;
   logic              busy_q, busy_d;

   assign any_req = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
   // last_grant_q: 1 when DM won the most recent grant; on contention the other port wins.
   logic last_grant_q, last_grant_d;

   assign grant_dm     = dm_req & (~if_req | ~last_grant_q);
   assign last_grant_d = (state_q == IDLE && any_req) ? grant_dm : last_grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_grant_q <= 1'b0;
      else        last_grant_q <= last_grant_d;
   end
`else
   assign grant_dm = dm_req;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = STROBE;
         STROBE:  state_d = HOLD;
         HOLD:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes and acks are computed one state early so they appear registered in their own cycle.
   always_comb begin
      grant_dm_d       = grant_dm_q;
      we_d             = we_q;
      err_d            = err_q;
      mem_address_d    = mem_address_q;
      mem_write_data_d = mem_write_data_q;
      mem_byte_d       = mem_byte_q;
      mem_read_d       = 1'b0;
      mem_write_d      = 1'b0;
      if_ack_d         = 1'b0;
      if_err_d         = 1'b0;
      if_rdata_d       = '0;
      dm_ack_d         = 1'b0;
      dm_err_d         = 1'b0;
      dm_rdata_d       = '0;
      resp_data        = '0;
      busy_d           = (state_d != IDLE);

      if (state_q == IDLE && any_req) begin
         grant_dm_d = grant_dm;
         if (grant_dm) begin
            we_d             = dm_we;
            err_d            = ~dm_byte & (dm_addr[1:0] != 2'b00);
            mem_address_d    = dm_addr;
            mem_byte_d       = dm_byte;
            mem_write_data_d = dm_byte ? {{(DATA_W-8){1'b0}}, dm_wdata[7:0]} : dm_wdata;
         end else begin
            we_d             = 1'b0;
            err_d            = (if_addr[1:0] != 2'b00);
            mem_address_d    = if_addr;
            mem_byte_d       = 1'b0;
            mem_write_data_d = '0;
         end
         mem_read_d  = ~we_d & ~err_d;
         mem_write_d = we_d & ~err_d;
      end

      if (state_q == HOLD) begin
         resp_data = (~we_q & ~err_q) ? mem_read_data : '0;
         if (grant_dm_q) begin
            dm_ack_d   = 1'b1;
            dm_err_d   = err_q;
            dm_rdata_d = resp_data;
         end else begin
            if_ack_d   = 1'b1;
            if_err_d   = err_q;
            if_rdata_d = resp_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_dm_q       <= 1'b0;
         we_q             <= 1'b0;
         err_q            <= 1'b0;
         mem_address_q    <= '0;
         mem_write_data_q <= '0;
         mem_byte_q       <= 1'b0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         if_ack_q         <= 1'b0;
         if_err_q         <= 1'b0;
         if_rdata_q       <= '0;
         dm_ack_q         <= 1'b0;
         dm_err_q         <= 1'b0;
         dm_rdata_q       <= '0;
         busy_q           <= 1'b0;
      end else begin
         grant_dm_q       <= grant_dm_d;
         we_q             <= we_d;
         err_q            <= err_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
         mem_byte_q       <= mem_byte_d;
         mem_read_q       <= mem_read_d;
         mem_write_q      <= mem_write_d;
         if_ack_q         <= if_ack_d;
         if_err_q         <= if_err_d;
         if_rdata_q       <= if_rdata_d;
         dm_ack_q         <= dm_ack_d;
         dm_err_q         <= dm_err_d;
         dm_rdata_q       <= dm_rdata_d;
         busy_q           <= busy_d;
      end
   end

   assign if_ack             = if_ack_q;
   assign if_err             = if_err_q;
   assign if_rdata           = if_rdata_q;
   assign dm_ack             = dm_ack_q;
   assign dm_err             = dm_err_q;
   assign dm_rdata           = dm_rdata_q;
   assign mem_address        = mem_address_q;
   assign mem_write_data     = mem_write_data_q;
   assign mem_byteOperations = mem_byte_q;
   assign mem_memRead        = mem_read_q;
   assign mem_memWrite       = mem_write_q;
   assign busy               = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter; expected values are hand-computed.
module tb_mem_access_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [17:0] if_addr;
   logic        if_ack;
   logic        if_err;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic        dm_byte;
   logic [17:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic        dm_err;
   logic [31:0] dm_rdata;
   logic [17:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_byteOperations;
   logic        mem_memRead;
   logic        mem_memWrite;
   logic [31:0] mem_read_data;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   mem_access_arbiter #(.ADDR_W(18), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_byteOperations(mem_byteOperations), .mem_memRead(mem_memRead),
      .mem_memWrite(mem_memWrite), .mem_read_data(mem_read_data), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ifReq, input logic [17:0] ifAddr, input logic dmReq,
                                input logic dmWe, input logic dmByte, input logic [17:0] dmAddr,
                                input logic [31:0] dmWdata);
      if_req   = ifReq;
      if_addr  = ifAddr;
      dm_req   = dmReq;
      dm_we    = dmWe;
      dm_byte  = dmByte;
      dm_addr  = dmAddr;
      dm_wdata = dmWdata;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_rd"},   32'(mem_memRead), 32'd0);
      checkOutput({tag, "_wr"},   32'(mem_memWrite), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_ack"},  32'({if_ack, dm_ack, if_err, dm_err}), 32'd0);
      checkOutput({tag, "_addr"}, 32'(mem_address), 32'd0);
      checkOutput({tag, "_wd"},   32'(mem_write_data), 32'd0);
      checkOutput({tag, "_rdat"}, if_rdata | dm_rdata, 32'd0);
   endtask

   int   n;
   logic gotIf, gotDm, expDm;

   initial begin
      rst_n = 1'b0;
      mem_read_data = 32'h0;
      applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      #3;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      nextCycle();

      // Aligned fetch
      mem_read_data = 32'h12345678;
      applyStimulus(1'b1, 18'h00010, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      nextCycle();
      checkOutput("fetch_c1_rd",   32'(mem_memRead), 32'd1);
      checkOutput("fetch_c1_wr",   32'(mem_memWrite), 32'd0);
      checkOutput("fetch_c1_addr", 32'(mem_address), 32'h10);
      checkOutput("fetch_c1_busy", 32'(busy), 32'd1);
      checkOutput("fetch_c1_ack",  32'(if_ack), 32'd0);
      nextCycle();
      checkOutput("fetch_c2_rd",   32'(mem_memRead), 32'd0);
      nextCycle();
      checkOutput("fetch_c3_ack",  32'(if_ack), 32'd1);
      checkOutput("fetch_c3_data", if_rdata, 32'h12345678);
      checkOutput("fetch_c3_err",  32'(if_err), 32'd0);
      checkOutput("fetch_c3_dack", 32'(dm_ack), 32'd0);
      checkOutput("fetch_c3_rd",   32'(mem_memRead), 32'd0);
      applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      nextCycle();
      checkOutput("fetch_c4_ack",  32'(if_ack), 32'd0);
      checkOutput("fetch_c4_data", if_rdata, 32'd0);
      checkOutput("fetch_c4_busy", 32'(busy), 32'd0);

      // Byte store
      applyStimulus(1'b0, 18'h0, 1'b1, 1'b1, 1'b1, 18'h00007, 32'hDEADBEAB);
      nextCycle();
      checkOutput("sb_c1_wr",   32'(mem_memWrite), 32'd1);
      checkOutput("sb_c1_rd",   32'(mem_memRead), 32'd0);
      checkOutput("sb_c1_byte", 32'(mem_byteOperations), 32'd1);
      checkOutput("sb_c1_wd",   mem_write_data, 32'h000000AB);
      checkOutput("sb_c1_addr", 32'(mem_address), 32'h7);
      nextCycle();
      checkOutput("sb_c2_wr",   32'(mem_memWrite), 32'd0);
      nextCycle();
      checkOutput("sb_c3_ack",  32'(dm_ack), 32'd1);
      checkOutput("sb_c3_data", dm_rdata, 32'd0);
      checkOutput("sb_c3_err",  32'(dm_err), 32'd0);
      checkOutput("sb_c3_iack", 32'(if_ack), 32'd0);
      applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      nextCycle();
      checkOutput("sb_hold_addr", 32'(mem_address), 32'h7);
      checkOutput("sb_hold_wd",   mem_write_data, 32'h000000AB);

      // Misaligned word load: no strobe at all, error ack
      mem_read_data = 32'h55AA55AA;
      applyStimulus(1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 18'h00006, 32'h0);
      for (int c = 1; c <= 3; c++) begin
         nextCycle();
         checkOutput("mis_strobe", 32'({mem_memRead, mem_memWrite}), 32'd0);
      end
      checkOutput("mis_c3_ack",  32'(dm_ack), 32'd1);
      checkOutput("mis_c3_err",  32'(dm_err), 32'd1);
      checkOutput("mis_c3_data", dm_rdata, 32'd0);
      applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      nextCycle();
      checkOutput("mis_c4_err",  32'(dm_err), 32'd0);

      // Byte load from an odd address is legal
      applyStimulus(1'b0, 18'h0, 1'b1, 1'b0, 1'b1, 18'h00003, 32'h0);
      nextCycle();
      checkOutput("lb_c1_rd", 32'(mem_memRead), 32'd1);
      nextCycle();
      nextCycle();
      checkOutput("lb_c3_ack",  32'(dm_ack), 32'd1);
      checkOutput("lb_c3_err",  32'(dm_err), 32'd0);
      checkOutput("lb_c3_data", dm_rdata, 32'h55AA55AA);
      applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      nextCycle();

      // Misaligned fetch
      applyStimulus(1'b1, 18'h00002, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      nextCycle();
      checkOutput("mif_c1_rd", 32'(mem_memRead), 32'd0);
      nextCycle();
      nextCycle();
      checkOutput("mif_c3_ack",  32'(if_ack), 32'd1);
      checkOutput("mif_c3_err",  32'(if_err), 32'd1);
      checkOutput("mif_c3_data", if_rdata, 32'd0);
      applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      nextCycle();

      // Reset while the read strobe is high
      applyStimulus(1'b1, 18'h00020, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      nextCycle();
      checkOutput("rst_pre_rd", 32'(mem_memRead), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkAllZero("rst_mid");
      applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         nextCycle();
         checkOutput("rst_after_idle", 32'({mem_memRead, mem_memWrite, busy, if_ack}), 32'd0);
      end

      // Contention: both requests held across four accesses
      mem_read_data = 32'h0BADBEEF;
      applyStimulus(1'b1, 18'h00020, 1'b1, 1'b0, 1'b0, 18'h00040, 32'h0);
      for (int a = 0; a < 4; a++) begin
         n = 0;
         gotIf = 1'b0;
         gotDm = 1'b0;
         while (n < 8 && !gotIf && !gotDm) begin
            nextCycle();
            n++;
            gotIf = if_ack;
            gotDm = dm_ack;
         end
`ifdef MEM_ARB_RR_EN
         expDm = (a % 2 == 0);
`else
         expDm = 1'b1;
`endif
         checkOutput("arb_latency", 32'(n), (a == 0) ? 32'd3 : 32'd4);
         checkOutput("arb_dm_ack",  32'(gotDm), 32'(expDm));
         checkOutput("arb_if_ack",  32'(gotIf), 32'(!expDm));
         checkOutput("arb_rdata",   expDm ? dm_rdata : if_rdata, 32'h0BADBEEF);
      end
      applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      nextCycle();
      checkOutput("arb_end_busy", 32'(busy), 32'd0);

      // Reset during HOLD of a load, then the same request completes
      mem_read_data = 32'hCAFEF00D;
      applyStimulus(1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 18'h00008, 32'h0);
      nextCycle();
      nextCycle();
      checkOutput("hrst_hold_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("hrst_ack",  32'(dm_ack), 32'd0);
      checkOutput("hrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("hrst_ack_low", 32'(dm_ack), 32'd0);
      rst_n = 1'b1;
      n = 0;
      gotDm = 1'b0;
      while (n < 8 && !gotDm) begin
         nextCycle();
         n++;
         gotDm = dm_ack;
      end
      checkOutput("hrst_latency", 32'(n), 32'd3);
      checkOutput("hrst_data",    dm_rdata, 32'hCAFEF00D);
      applyStimulus(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
      nextCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
